// File: rtl/mix_invmix_stream.sv
// rtl/mix_invmix_stream.sv - streaming AES MixColumns / InvMixColumns engine

module mix_invmix_stream #(
   parameter int LANES = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_mode,
   input  logic [127:0]     in_state,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_state,
   output logic             out_mode,
   output logic             busy,
   output logic [CNT_W-1:0] blk_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PROC = 2'd1,
      DONE = 2'd2
   } state_t;

   generate
      if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
         $error("mix_invmix_stream: LANES must be 1, 2 or 4");
      end
   endgenerate

   // Column index advance per PROC cycle (4 lanes wraps to 0) and the
   // index of the final PROC cycle of a block.
   localparam logic [1:0] STEP     = 2'(LANES);
   localparam logic [1:0] LAST_IDX = 2'(4 - LANES);

   // Multiply a byte by a 4-bit GF(2^8) constant: every coefficient of
   // both matrices (01,02,03,09,0b,0d,0e) fits in 4 bits, so a sum of
   // x, 2x, 4x, 8x covers them all.
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm4(input logic [7:0] b, input logic [3:0] k);
      logic [7:0] x2;
      logic [7:0] x4;
      logic [7:0] x8;
      x2 = xt(b);
      x4 = xt(x2);
      x8 = xt(x4);
      return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
             (k[1] ? x2 : 8'h00) ^ (k[0] ? b  : 8'h00);
   endfunction

   // Both matrices are circulant; only the first row differs by mode.
   function automatic logic [31:0] mix_col(input logic [31:0] col, input logic fwd);
      logic [3:0] k0;
      logic [3:0] k1;
      logic [3:0] k2;
      logic [3:0] k3;
      logic [7:0] a0;
      logic [7:0] a1;
      logic [7:0] a2;
      logic [7:0] a3;
      k0 = fwd ? 4'h2 : 4'he;
      k1 = fwd ? 4'h3 : 4'hb;
      k2 = fwd ? 4'h1 : 4'hd;
      k3 = fwd ? 4'h1 : 4'h9;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {gm4(a0, k0) ^ gm4(a1, k1) ^ gm4(a2, k2) ^ gm4(a3, k3),
              gm4(a0, k3) ^ gm4(a1, k0) ^ gm4(a2, k1) ^ gm4(a3, k2),
              gm4(a0, k2) ^ gm4(a1, k3) ^ gm4(a2, k0) ^ gm4(a3, k1),
              gm4(a0, k1) ^ gm4(a1, k2) ^ gm4(a2, k3) ^ gm4(a3, k0)};
   endfunction

   state_t           state;
   state_t           state_next;
   logic [127:0]     src_q;
   logic [127:0]     res_q;
   logic [127:0]     res_next;
   logic             mode_q;
   logic [1:0]       idx_q;
   logic [CNT_W-1:0] cnt_q;
   logic             take_in;
   logic             give_out;
   logic             last_step;

   assign take_in   = in_valid && in_ready;
   assign give_out  = out_valid && out_ready;
   assign last_step = (idx_q == LAST_IDX);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and handshake outputs; DONE forwards out_ready so a new
   // block can be taken on the same edge the result leaves
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = PROC;
            end
         end
         PROC: begin
            busy = 1'b1;
            if (last_step) begin
               state_next = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) begin
               state_next = in_valid ? PROC : IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Column datapath: transform the LANES columns starting at idx; column c
   // sits at bit offset 32*(3-c), and 3-c on two bits is ~c
   always_comb begin
      res_next = res_q;
      for (int l = 0; l < LANES; l++) begin
         res_next[{~(idx_q + 2'(l)), 5'b0} +: 32] =
            mix_col(src_q[{~(idx_q + 2'(l)), 5'b0} +: 32], mode_q);
      end
   end

   // Block capture and column write-back; the result register only moves
   // in PROC, so it holds steady for the whole DONE stall
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src_q  <= '0;
         res_q  <= '0;
         mode_q <= 1'b0;
         idx_q  <= '0;
      end else if (take_in) begin
         src_q  <= in_state;
         mode_q <= in_mode;
         idx_q  <= '0;
      end else if (state == PROC) begin
         res_q  <= res_next;
         idx_q  <= idx_q + STEP;
      end
   end

   // Handoff counter, free-running wrap
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (give_out) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign out_state = res_q;
   assign out_mode  = mode_q;
   assign blk_cnt   = cnt_q;

endmodule

// File: tb/tb_mix_invmix_stream.sv
// tb/tb_mix_invmix_stream.sv - scoreboard bench for mix_invmix_stream

module tb_mix_invmix_stream;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [3:0]        in_valid;
   logic [3:0]        in_ready;
   logic [3:0]        in_mode;
   logic [3:0]        out_valid;
   logic [3:0]        out_ready;
   logic [3:0]        out_mode;
   logic [3:0]        busy;
   logic [3:0][127:0] in_state;
   logic [3:0][127:0] out_state;
   logic [3:0][15:0]  blk_cnt;
   logic [3:0]        blk_cnt4;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [127:0] st;
      logic         md;
      logic [127:0] ex;
   } stim_t;

   typedef struct {
      logic [127:0] ex;
      logic         md;
   } exp_t;

   stim_t        stim_q[$];
   exp_t         exp_q[$];
   logic [127:0] cap_q[$];

   always #5 clk = ~clk;

   assign blk_cnt[3] = {12'd0, blk_cnt4};

   mix_invmix_stream #(.LANES(1), .CNT_W(16)) u_l1 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_mode(in_mode[0]), .in_state(in_state[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_state(out_state[0]), .out_mode(out_mode[0]),
      .busy(busy[0]), .blk_cnt(blk_cnt[0])
   );

   mix_invmix_stream #(.LANES(2), .CNT_W(16)) u_l2 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_mode(in_mode[1]), .in_state(in_state[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_state(out_state[1]), .out_mode(out_mode[1]),
      .busy(busy[1]), .blk_cnt(blk_cnt[1])
   );

   mix_invmix_stream #(.LANES(4), .CNT_W(16)) u_l4 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_mode(in_mode[2]), .in_state(in_state[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_state(out_state[2]), .out_mode(out_mode[2]),
      .busy(busy[2]), .blk_cnt(blk_cnt[2])
   );

   mix_invmix_stream #(.LANES(4), .CNT_W(4)) u_c4 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_mode(in_mode[3]), .in_state(in_state[3]),
      .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_state(out_state[3]), .out_mode(out_mode[3]),
      .busy(busy[3]), .blk_cnt(blk_cnt4)
   );

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Shift-and-add GF(2^8) multiply, reduction poly 0x11B
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] s, input logic m);
      logic [7:0]   row0 [4];
      logic [7:0]   acc;
      logic [127:0] r;
      if (m) begin
         row0[0] = 8'h02; row0[1] = 8'h03; row0[2] = 8'h01; row0[3] = 8'h01;
      end else begin
         row0[0] = 8'h0e; row0[1] = 8'h0b; row0[2] = 8'h0d; row0[3] = 8'h09;
      end
      r = '0;
      for (int k = 0; k < 4; k++) begin
         for (int rw = 0; rw < 4; rw++) begin
            acc = 8'h00;
            for (int c = 0; c < 4; c++) begin
               acc = acc ^ gmul(row0[(c - rw) & 3], s[127 - 32*k - 8*c -: 8]);
            end
            r[127 - 32*k - 8*rw -: 8] = acc;
         end
      end
      return r;
   endfunction

   task automatic add(input logic [127:0] st, input logic md, input logic [127:0] ex);
      stim_t s;
      s.st = st;
      s.md = md;
      s.ex = ex;
      stim_q.push_back(s);
   endtask

   // Drives stim_q into instance d, consumes results against the scoreboard.
   task automatic run_stream(input int d, input bit bp, input bit gaps, input bit chk_gap, input string tag);
      int          n;
      int          sent;
      int          got;
      int          budget;
      logic [15:0] c0;
      logic [15:0] mask;
      n      = stim_q.size();
      sent   = 0;
      got    = 0;
      budget = 40 * n + 40;
      c0     = blk_cnt[d];
      mask   = (d == 3) ? 16'h000f : 16'hffff;
      exp_q.delete();
      cap_q.delete();
      fork
         begin : drv
            int dc = 0;
            bit hold = 0;
            exp_t e;
            while (sent < n && dc < budget) begin
               if (!hold && gaps && $urandom_range(0, 3) == 0) begin
                  in_valid[d] = 1'b0;
                  in_state[d] = rnd128();
                  in_mode[d]  = 1'($urandom());
               end else begin
                  in_valid[d] = 1'b1;
                  in_state[d] = stim_q[sent].st;
                  in_mode[d]  = stim_q[sent].md;
               end
               @(negedge clk);
               hold = in_valid[d] && !in_ready[d];
               if (in_valid[d] && in_ready[d]) begin
                  e.ex = stim_q[sent].ex;
                  e.md = stim_q[sent].md;
                  exp_q.push_back(e);
                  sent++;
               end
               @(posedge clk);
               #1;
               dc++;
            end
            in_valid[d] = 1'b0;
            in_mode[d]  = 1'($urandom());
            in_state[d] = rnd128();
         end
         begin : con
            bit           stalled = 0;
            logic [127:0] held = '0;
            logic         hmode = 1'b0;
            int           cc = 0;
            int           last = -1;
            exp_t         e;
            while (got < n && cc < budget) begin
               out_ready[d] = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
               @(negedge clk);
               cc++;
               if (stalled) begin
                  tests++;
                  if (out_valid[d] !== 1'b1 || out_state[d] !== held || out_mode[d] !== hmode) begin
                     fails++;
                     $display("FAIL %s_hold inst=%0d: got v=%b %h m=%b, expected v=1 %h m=%b",
                              tag, d, out_valid[d], out_state[d], out_mode[d], held, hmode);
                  end
               end
               stalled = 0;
               if (out_valid[d] === 1'b1) begin
                  if (out_ready[d]) begin
                     tests++;
                     if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL %s_extra inst=%0d: got %h, expected no result", tag, d, out_state[d]);
                     end else begin
                        e = exp_q.pop_front();
                        if (out_state[d] !== e.ex || out_mode[d] !== e.md) begin
                           fails++;
                           $display("FAIL %s_data inst=%0d: got %h m=%b, expected %h m=%b",
                                    tag, d, out_state[d], out_mode[d], e.ex, e.md);
                        end
                     end
                     cap_q.push_back(out_state[d]);
                     if (chk_gap && last >= 0) begin
                        tests++;
                        if (cc - last != 2) begin
                           fails++;
                           $display("FAIL %s_gap inst=%0d: got %0d cycles, expected 2", tag, d, cc - last);
                        end
                     end
                     last = cc;
                     got++;
                  end else begin
                     stalled = 1;
                     held    = out_state[d];
                     hmode   = out_mode[d];
                  end
               end
               @(posedge clk);
               #1;
            end
            out_ready[d] = 1'b0;
            tests++;
            if (got != n) begin
               fails++;
               $display("FAIL %s_count inst=%0d: got %0d results, expected %0d", tag, d, got, n);
            end
         end
      join
      tests++;
      if (blk_cnt[d] !== ((c0 + 16'(n)) & mask)) begin
         fails++;
         $display("FAIL %s_blk_cnt inst=%0d: got %0d, expected %0d", tag, d, blk_cnt[d], (c0 + 16'(n)) & mask);
      end
      stim_q.delete();
   endtask

   task automatic test_reset();
      for (int d = 0; d < 4; d++) begin
         tests++;
         if ({in_ready[d], out_valid[d], busy[d], out_mode[d]} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_ctrl inst=%0d: got rdy/vld/busy/mode=%b%b%b%b, expected 1000",
                     d, in_ready[d], out_valid[d], busy[d], out_mode[d]);
         end
         tests++;
         if (out_state[d] !== 128'd0) begin
            fails++;
            $display("FAIL reset_state inst=%0d: got %h, expected 0", d, out_state[d]);
         end
         tests++;
         if (blk_cnt[d] !== 16'd0) begin
            fails++;
            $display("FAIL reset_cnt inst=%0d: got %0d, expected 0", d, blk_cnt[d]);
         end
      end
   endtask

   task automatic test_vectors(input int d);
      add({32'hdb135345, 32'hf20a225c, 32'hd4d4d4d5, 32'h01010101}, 1'b1,
          {32'h8e4da1bc, 32'h9fdc589d, 32'hd5d5d7d6, 32'h01010101});
      add({32'h8e4da1bc, 32'hc6c6c6c6, 32'h01010101, 32'h8e4da1bc}, 1'b0,
          {32'hdb135345, 32'hc6c6c6c6, 32'h01010101, 32'hdb135345});
      add({32'hc6c6c6c6, 32'h01010101, 32'hc6c6c6c6, 32'h01010101}, 1'b1,
          {32'hc6c6c6c6, 32'h01010101, 32'hc6c6c6c6, 32'h01010101});
      run_stream(d, 1'b1, 1'b1, 1'b0, "vec");
   endtask

   task automatic test_latency(input int d, input int exp_lat);
      logic [127:0] st;
      int           k;
      st           = {32'hdb135345, 32'hf20a225c, 32'hdb135345, 32'hf20a225c};
      in_valid[d]  = 1'b1;
      in_state[d]  = st;
      in_mode[d]   = 1'b1;
      out_ready[d] = 1'b0;
      @(negedge clk);
      tests++;
      if (in_ready[d] !== 1'b1) begin
         fails++;
         $display("FAIL lat_ready inst=%0d: got %b, expected 1", d, in_ready[d]);
      end
      @(posedge clk);
      #1;
      in_valid[d] = 1'b0;
      in_mode[d]  = 1'b0;
      in_state[d] = rnd128();
      k = 0;
      while (out_valid[d] !== 1'b1 && k < 16) begin
         @(posedge clk);
         #1;
         k++;
      end
      tests++;
      if (k != exp_lat) begin
         fails++;
         $display("FAIL lat_edges inst=%0d: got %0d, expected %0d", d, k, exp_lat);
      end
      tests++;
      if (out_state[d] !== {32'h8e4da1bc, 32'h9fdc589d, 32'h8e4da1bc, 32'h9fdc589d} || out_mode[d] !== 1'b1) begin
         fails++;
         $display("FAIL lat_data inst=%0d: got %h m=%b, expected 8e4da1bc9fdc589d8e4da1bc9fdc589d m=1",
                  d, out_state[d], out_mode[d]);
      end
      out_ready[d] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[d] = 1'b0;
   endtask

   task automatic test_mix_inv(input int d, input int n);
      logic [127:0] orig[$];
      logic [127:0] s;
      for (int i = 0; i < n; i++) begin
         s = rnd128();
         orig.push_back(s);
         add(s, 1'b1, model(s, 1'b1));
      end
      run_stream(d, 1'b1, 1'b1, 1'b0, "mix");
      for (int i = 0; i < n && i < cap_q.size(); i++) begin
         add(cap_q[i], 1'b0, orig[i]);
      end
      run_stream(d, 1'b1, 1'b1, 1'b0, "inv");
   endtask

   task automatic test_back_to_back();
      logic [127:0] s;
      for (int i = 0; i < 8; i++) begin
         s = rnd128();
         add(s, 1'(i), model(s, 1'(i)));
      end
      run_stream(2, 1'b0, 1'b0, 1'b1, "b2b");
   endtask

   task automatic test_reset_mid();
      logic [127:0] s0;
      logic [127:0] s1;
      logic [127:0] s2;
      int           stale;
      int           seen;
      int           good;
      s0 = rnd128();
      s1 = rnd128();
      s2 = rnd128();
      in_valid[0] = 1'b1; in_state[0] = s0; in_mode[0] = 1'b1; out_ready[0] = 1'b0;
      in_valid[2] = 1'b1; in_state[2] = s2; in_mode[2] = 1'b0; out_ready[2] = 1'b0;
      @(negedge clk);
      tests++;
      if ({in_ready[0], in_ready[2]} !== 2'b11) begin
         fails++;
         $display("FAIL rmid_accept: got %b%b, expected 11", in_ready[0], in_ready[2]);
      end
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      in_valid[2] = 1'b0;
      @(posedge clk);
      #1;
      tests++;
      if ({busy[0], out_valid[0], out_valid[2]} !== 3'b101) begin
         fails++;
         $display("FAIL rmid_pre: got busy0/vld0/vld2=%b%b%b, expected 101", busy[0], out_valid[0], out_valid[2]);
      end
      #2;
      reset = 1'b1;
      #1;
      tests++;
      if ({out_valid[0], in_ready[0], busy[0], out_valid[2], in_ready[2], busy[2]} !== 6'b010010) begin
         fails++;
         $display("FAIL rmid_ctrl: got %b%b%b%b%b%b, expected 010010",
                  out_valid[0], in_ready[0], busy[0], out_valid[2], in_ready[2], busy[2]);
      end
      tests++;
      if (blk_cnt[0] !== 16'd0 || blk_cnt[2] !== 16'd0 || out_state[0] !== 128'd0) begin
         fails++;
         $display("FAIL rmid_clear: got cnt0=%0d cnt2=%0d st0=%h, expected 0 0 0", blk_cnt[0], blk_cnt[2], out_state[0]);
      end
      @(posedge clk);
      #1;
      in_valid[1] = 1'b1; in_state[1] = s1; in_mode[1] = 1'b1;
      out_ready[0] = 1'b1; out_ready[1] = 1'b1; out_ready[2] = 1'b1;
      reset = 1'b0;
      @(negedge clk);
      tests++;
      if (in_ready[1] !== 1'b1) begin
         fails++;
         $display("FAIL rmid_first_ready: got %b, expected 1", in_ready[1]);
      end
      @(posedge clk);
      #1;
      in_valid[1] = 1'b0;
      tests++;
      if (busy[1] !== 1'b1) begin
         fails++;
         $display("FAIL rmid_first_edge: got busy=%b, expected 1", busy[1]);
      end
      stale = 0;
      seen  = 0;
      good  = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid[0] !== 1'b0 || out_valid[2] !== 1'b0) stale++;
         if (out_valid[1] === 1'b1) begin
            seen++;
            if (out_state[1] === model(s1, 1'b1)) good++;
         end
         @(posedge clk);
         #1;
      end
      tests++;
      if (stale != 0) begin
         fails++;
         $display("FAIL rmid_stale: got %0d stale valid cycles, expected 0", stale);
      end
      tests++;
      if (seen != 1 || good != 1) begin
         fails++;
         $display("FAIL rmid_after: got %0d results (%0d correct), expected 1 (1)", seen, good);
      end
      out_ready[0] = 1'b0;
      out_ready[1] = 1'b0;
      out_ready[2] = 1'b0;
   endtask

   task automatic test_counter_wrap();
      logic [127:0] s;
      for (int i = 0; i < 17; i++) begin
         s = rnd128();
         add(s, 1'b1, model(s, 1'b1));
      end
      run_stream(3, 1'b0, 1'b1, 1'b0, "wrap");
      tests++;
      if (blk_cnt4 !== 4'd1) begin
         fails++;
         $display("FAIL wrap_cnt: got %0d, expected 1", blk_cnt4);
      end
   endtask

   initial begin
      in_valid  = '0;
      in_mode   = '0;
      out_ready = '0;
      in_state  = '0;
      reset     = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      reset = 1'b0;
      for (int d = 0; d < 3; d++) test_vectors(d);
      test_latency(0, 4);
      test_latency(1, 2);
      test_latency(2, 1);
      for (int d = 0; d < 3; d++) test_mix_inv(d, 5);
      test_back_to_back();
      test_reset_mid();
      test_counter_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
